// File: rtl/led_axil_pkg.sv
// Shared register map, control bit positions and response codes for the LED AXI4-Lite responder.
package led_axil_pkg;

    localparam int NUM_REGS = 4;

    localparam logic [1:0] REG_LED     = 2'd0;
    localparam logic [1:0] REG_CTRL    = 2'd1;
    localparam logic [1:0] REG_PERIOD  = 2'd2;
    localparam logic [1:0] REG_SCRATCH = 2'd3;

    localparam int CTRL_BLINK_EN_BIT = 0;
    localparam int CTRL_INVERT_BIT   = 1;

    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Byte-lane merge of a write into an existing 32-bit register value.
    function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                               input logic [31:0] wr_val,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) begin
                res[8*i +: 8] = wr_val[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/led_blink_gen.sv
// LED driver: registered output of the LED value, optionally blanked by a blink phase and inverted.
// One cycle from register change to pin; no handshake.
module led_blink_gen
    import led_axil_pkg::*;
#(
    parameter int LED_WIDTH = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [LED_WIDTH-1:0] led_value_i,
    input  logic                 blink_en_i,
    input  logic                 invert_i,
    input  logic [31:0]          period_i,
    output logic [LED_WIDTH-1:0] led_o
);

    logic [31:0]          cnt_q, cnt_d;
    logic                 phase_q, phase_d;
    logic [LED_WIDTH-1:0] led_q, led_d;

    always_comb begin
        cnt_d   = '0;
        phase_d = 1'b0;
        // The all-ones wrap keeps a counter stranded above a newly shrunk period from locking up.
        if (blink_en_i) begin
            if ((cnt_q == period_i) || (cnt_q == '1)) begin
                cnt_d   = '0;
                phase_d = !phase_q;
            end else begin
                cnt_d   = cnt_q + 32'd1;
                phase_d = phase_q;
            end
        end
        led_d = ((blink_en_i && phase_q) ? '0 : led_value_i) ^ {LED_WIDTH{invert_i}};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
            led_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            led_q   <= led_d;
        end
    end

    assign led_o = led_q;

endmodule

// File: rtl/led_axil_responder.sv
// AXI4-Lite slave with four read/write registers driving the LED pins; one outstanding write and read.
// Write response one cycle after AW and W are both available; read data one cycle after AR; B/R hold until ready.
module led_axil_responder
    import led_axil_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int LED_WIDTH          = 8
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [LED_WIDTH-1:0]            LED
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = C_S_AXI_DATA_WIDTH / 8;

    logic          live_q;
    logic          aw_held_q, aw_held_d;
    logic [1:0]    aw_idx_q, aw_idx_d;
    logic          w_held_q, w_held_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic          bvalid_q, bvalid_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [DW-1:0] regs_q [NUM_REGS];
    logic [DW-1:0] regs_d [NUM_REGS];

    logic          awready, wready, arready;
    logic          aw_hs, w_hs, ar_hs, commit;
    logic [1:0]    wr_idx, rd_idx;
    logic [DW-1:0] wr_data;
    logic [SW-1:0] wr_strb;
    logic          unused_ok;

    // live_q keeps every READY low while reset is asserted and for the first edge after release.
    assign awready = live_q && !aw_held_q && !bvalid_q;
    assign wready  = live_q && !w_held_q && !bvalid_q;
    assign arready = live_q && !rvalid_q;

    assign aw_hs  = S_AXI_AWVALID && awready;
    assign w_hs   = S_AXI_WVALID && wready;
    assign ar_hs  = S_AXI_ARVALID && arready;
    assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign wr_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[3:2];
    assign wr_data = w_held_q ? wdata_q : S_AXI_WDATA;
    assign wr_strb = w_held_q ? wstrb_q : S_AXI_WSTRB;
    assign rd_idx  = S_AXI_ARADDR[3:2];

    always_comb begin
        aw_held_d = aw_held_q;
        aw_idx_d  = aw_idx_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (commit) begin
            aw_held_d      = 1'b0;
            w_held_d       = 1'b0;
            bvalid_d       = 1'b1;
            regs_d[wr_idx] = byte_merge(regs_q[wr_idx], wr_data, wr_strb);
        end else begin
            if (aw_hs) begin
                aw_held_d = 1'b1;
                aw_idx_d  = S_AXI_AWADDR[3:2];
            end
            if (w_hs) begin
                w_held_d = 1'b1;
                wdata_d  = S_AXI_WDATA;
                wstrb_d  = S_AXI_WSTRB;
            end
        end
        if (bvalid_q && S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // Reads sample regs_q, so a same-edge write to the same register is not yet visible.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = regs_q[rd_idx];
        end else if (rvalid_q && S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            live_q    <= 1'b0;
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            live_q    <= 1'b1;
            aw_held_q <= aw_held_d;
            aw_idx_q  <= aw_idx_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    led_blink_gen #(
        .LED_WIDTH (LED_WIDTH)
    ) u_blink (
        .clk_i       (ACLK),
        .rst_ni      (ARESETN),
        .led_value_i (regs_q[REG_LED][LED_WIDTH-1:0]),
        .blink_en_i  (regs_q[REG_CTRL][CTRL_BLINK_EN_BIT]),
        .invert_i    (regs_q[REG_CTRL][CTRL_INVERT_BIT]),
        .period_i    (regs_q[REG_PERIOD]),
        .led_o       (LED)
    );

    assign S_AXI_AWREADY = awready;
    assign S_AXI_WREADY  = wready;
    assign S_AXI_BRESP   = RESP_OKAY;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = RESP_OKAY;
    assign S_AXI_RVALID  = rvalid_q;

    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_led_axil_responder.sv
// Randomized and directed bench for led_axil_responder against a register-array reference model.
module tb_led_axil_responder;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [7:0]  led;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] model [4];

    always #5 clk = ~clk;

    led_axil_responder #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (4),
        .LED_WIDTH          (8)
    ) dut (
        .ACLK          (clk),
        .ARESETN       (arst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .LED           (led)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] model_led();
        return model[0][7:0] ^ {8{model[1][1]}};
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 4; i++) model[i] = '0;
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly, output int ncyc);
        bit aw_done;
        bit w_done;
        bit aw_fire;
        bit w_fire;
        int cyc;
        aw_done = 0;
        w_done  = 0;
        cyc     = 0;
        while (!(aw_done && w_done) && cyc < 100) begin
            if (aw_done && !w_done) check_eq("awready_held_low", {31'd0, awready}, 32'd0);
            if (w_done && !aw_done) check_eq("wready_held_low", {31'd0, wready}, 32'd0);
            awaddr  = addr;
            wdata   = data;
            wstrb   = strb;
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            step();
            if (aw_fire) aw_done = 1;
            if (w_fire) w_done = 1;
            cyc++;
        end
        awvalid = 1'b0;
        wvalid  = 1'b0;
        ncyc    = cyc;
        check_eq("wr_accepted", {30'd0, aw_done, w_done}, 32'd3);
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) model[addr[3:2]][8*i +: 8] = data[8*i +: 8];
        end
        check_eq("bvalid_after_commit", {31'd0, bvalid}, 32'd1);
        check_eq("bresp_okay", {30'd0, bresp}, 32'd0);
        for (int i = 0; i < b_dly; i++) begin
            step();
            check_eq("bvalid_hold", {31'd0, bvalid}, 32'd1);
            check_eq("awready_bp", {31'd0, awready}, 32'd0);
            check_eq("wready_bp", {31'd0, wready}, 32'd0);
        end
        bready = 1'b1;
        step();
        bready = 1'b0;
        check_eq("bvalid_cleared", {31'd0, bvalid}, 32'd0);
    endtask

    task automatic axi_read(input logic [3:0] addr, input int r_dly, output logic [31:0] got);
        bit fire;
        int cyc;
        logic [31:0] exp;
        fire    = 0;
        cyc     = 0;
        araddr  = addr;
        arvalid = 1'b1;
        while (!fire && cyc < 100) begin
            fire = arready;
            step();
            cyc++;
        end
        arvalid = 1'b0;
        exp = model[addr[3:2]];
        got = rdata;
        check_eq("ar_accepted", {31'd0, fire}, 32'd1);
        check_eq("rvalid_after_ar", {31'd0, rvalid}, 32'd1);
        check_eq("rdata", rdata, exp);
        check_eq("rresp_okay", {30'd0, rresp}, 32'd0);
        for (int i = 0; i < r_dly; i++) begin
            step();
            check_eq("rdata_stable", rdata, exp);
            check_eq("arready_bp", {31'd0, arready}, 32'd0);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        check_eq("rvalid_cleared", {31'd0, rvalid}, 32'd0);
    endtask

    // Blink pattern: after the first phase edge, LED must alternate a/b in runs of per+1 cycles.
    task automatic blink_check(input string tag, input logic [7:0] a, input logic [7:0] b, input int per);
        logic [7:0] s [64];
        logic [7:0] first;
        logic [7:0] other;
        logic [7:0] exp;
        int k;
        int run;
        run = per + 1;
        for (int i = 0; i < 64; i++) begin
            s[i] = led;
            step();
        end
        k = -1;
        for (int i = 1; i <= 2 * run; i++) begin
            if (k < 0 && s[i] != s[i-1]) k = i;
        end
        check_eq({tag, "_edge_found"}, {31'd0, (k > 0)}, 32'd1);
        if (k > 0) begin
            check_eq({tag, "_value_set"}, {31'd0, (s[k] == a || s[k] == b)}, 32'd1);
            first = (s[k] == a) ? a : b;
            other = (s[k] == a) ? b : a;
            check_eq({tag, "_before_edge"}, {24'd0, s[k-1]}, {24'd0, other});
            for (int i = k; i < k + 6 * run && i < 64; i++) begin
                exp = (((i - k) / run) % 2 == 0) ? first : other;
                check_eq(tag, {24'd0, s[i]}, {24'd0, exp});
            end
        end
    endtask

    initial begin
        int          cyc;
        logic [31:0] rd;
        logic [3:0]  a;
        logic [31:0] d;
        model_clear();

        // Reset state
        #12;
        check_eq("rst_awready", {31'd0, awready}, 32'd0);
        check_eq("rst_wready", {31'd0, wready}, 32'd0);
        check_eq("rst_arready", {31'd0, arready}, 32'd0);
        check_eq("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check_eq("rst_rvalid", {31'd0, rvalid}, 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_led", {24'd0, led}, 32'd0);
        check_eq("rst_resp", {28'd0, bresp, rresp}, 32'd0);
        step();
        arst_n = 1'b1;
        step();
        step();
        check_eq("post_rst_ready", {29'd0, awready, wready, arready}, 32'd7);

        // Sequential writes then reads
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0, cyc);
            check_eq("same_cycle_commit", cyc, 1);
        end
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), 0, rd);
            check_eq("seq_read", rd, 32'(i + 1));
        end

        // AW early / W early
        axi_write(4'hC, 32'hCAFE0001, 4'hF, 0, 5, 0, cyc);
        check_eq("aw_first_commit_cycle", cyc, 6);
        axi_write(4'hC, 32'hCAFE0002, 4'hF, 5, 0, 0, cyc);
        check_eq("w_first_commit_cycle", cyc, 6);
        axi_read(4'hC, 0, rd);
        check_eq("late_partner_read", rd, 32'hCAFE0002);

        // Byte strobes
        axi_write(4'hC, 32'hFFFFFFFF, 4'hF, 0, 0, 0, cyc);
        axi_write(4'hF, 32'h12345678, 4'b0101, 0, 0, 0, cyc);
        axi_read(4'hC, 0, rd);
        check_eq("strobe_merge", rd, 32'hFF34FF78);

        // Backpressure on B and R
        axi_write(4'h8, 32'h00000003, 4'hF, 0, 0, 10, cyc);
        axi_read(4'h9, 10, rd);
        check_eq("bp_read", rd, 32'h3);

        // Blink, then invert while blinking, then period 0
        axi_write(4'h0, 32'hA5, 4'hF, 0, 0, 0, cyc);
        axi_write(4'h4, 32'h1, 4'hF, 0, 0, 0, cyc);
        blink_check("blink", 8'hA5, 8'h00, 3);
        axi_write(4'h4, 32'h3, 4'hF, 0, 0, 0, cyc);
        blink_check("blink_inv", 8'h5A, 8'hFF, 3);
        axi_write(4'h4, 32'h0, 4'hF, 0, 0, 0, cyc);
        step();
        check_eq("blink_off_led", {24'd0, led}, 32'hA5);
        axi_write(4'h8, 32'h0, 4'hF, 0, 0, 0, cyc);
        axi_write(4'h4, 32'h1, 4'hF, 0, 0, 0, cyc);
        blink_check("blink_p0", 8'hA5, 8'h00, 0);
        axi_write(4'h4, 32'h0, 4'hF, 0, 0, 0, cyc);
        step();
        check_eq("blink_off_led2", {24'd0, led}, 32'hA5);

        // Random traffic, blink kept off
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 1) == 1) begin
                a = 4'($urandom_range(0, 15));
                d = $urandom;
                if (a[3:2] == 2'd1) d[0] = 1'b0;
                axi_write(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 2), cyc);
                step();
                check_eq("led_static", {24'd0, led}, {24'd0, model_led()});
            end else begin
                axi_read(4'($urandom_range(0, 15)), $urandom_range(0, 2), rd);
            end
        end

        // Reset while a read response is pending
        araddr  = 4'h0;
        arvalid = 1'b1;
        step();
        arvalid = 1'b0;
        check_eq("pre_rst_rvalid", {31'd0, rvalid}, 32'd1);
        arst_n = 1'b0;
        #1;
        check_eq("mid_rst_rvalid", {31'd0, rvalid}, 32'd0);
        check_eq("mid_rst_led", {24'd0, led}, 32'd0);
        check_eq("mid_rst_arready", {31'd0, arready}, 32'd0);
        step();
        arst_n = 1'b1;
        model_clear();
        step();
        step();
        check_eq("post_rst_led", {24'd0, led}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), 0, rd);
            check_eq("post_rst_reg", rd, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/led_axil_responder.md
Name: led_axil_responder

Overview:
- AXI4-Lite slave (responder) that terminates the master-side register accesses issued by the LED IP's AXI VIP master.
- Holds four 32-bit registers at offsets 0x0, 0x4, 0x8 and 0xC; every register reads back exactly what was written.
- Drives the LED outputs from REG0, with optional hardware blink and invert controlled by REG1 and REG2.
- Sits inside the LED IP between the AXI interconnect and the board pins.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4, byte address width; bits [3:2] select the register.
- LED_WIDTH, 8, number of LED pins, 1..32.

Ports:
- ACLK  in  1  single clock.
- ARESETN  in  1  asynchronous, active-low reset.
- S_AXI_AWADDR  in  ADDR_W  write address.
- S_AXI_AWPROT  in  3  ignored.
- S_AXI_AWVALID  in  1;  S_AXI_AWREADY  out  1.
- S_AXI_WDATA  in  32;  S_AXI_WSTRB  in  4;  S_AXI_WVALID  in  1;  S_AXI_WREADY  out  1.
- S_AXI_BRESP  out  2;  S_AXI_BVALID  out  1;  S_AXI_BREADY  in  1.
- S_AXI_ARADDR  in  ADDR_W;  S_AXI_ARPROT  in  3 (ignored);  S_AXI_ARVALID  in  1;  S_AXI_ARREADY  out  1.
- S_AXI_RDATA  out  32;  S_AXI_RRESP  out  2;  S_AXI_RVALID  out  1;  S_AXI_RREADY  in  1.
- LED  out  LED_WIDTH  LED drive.

Behaviour:
- Reset (ARESETN=0, asynchronous): all READY/VALID outputs, RDATA, REG0-REG3, blink counter, blink phase and LED go to 0. BRESP and RRESP are always 2'b00 (OKAY).
- Register map:
  - REG0: LED value.
  - REG1 control: bit0 = blink_en, bit1 = invert; other bits are stored but have no effect.
  - REG2: blink terminal count.
  - REG3: scratch.
- Address decode: addr[3:2] selects the register; addr[1:0] is ignored. There are no decode errors.
- Write channel: one outstanding write.
  - AWREADY=1 when no AW is latched and BVALID=0. WREADY=1 when no W is latched and BVALID=0.
  - AW and W are accepted independently in any order and either one is held until its partner arrives.
  - Commit edge: the edge where both AW and W are available, each either latched earlier or handshaking this cycle. On that edge:
    - Each byte i with WSTRB[i]=1 updates REG[addr[3:2]][8i+7:8i].
    - BVALID is set; both latches clear.
  - Best case latency: AW and W in the same cycle gives BVALID in the next cycle.
  - BVALID holds until BREADY; it clears on the B handshake edge. AW and W are not accepted while BVALID=1.
- Read channel: one outstanding read.
  - ARREADY = !RVALID.
  - On the AR handshake edge, RDATA is loaded with REG[araddr[3:2]] and RVALID is set.
  - RDATA and RVALID are held stable until RREADY; RVALID clears on that edge.
- Same-edge read and write to the same register: the read returns the pre-write value. Read and write channels are otherwise fully independent.
- Blink and LED:
  - With blink_en=0: counter=0, phase=0, LED = REG0[LED_WIDTH-1:0] ^ {LED_WIDTH{invert}}. LED is registered, so it updates one cycle after the register changes.
  - With blink_en=1: the counter increments each cycle. When counter==REG2 it wraps to 0 and phase toggles. REG2=0 therefore toggles phase every cycle.
  - LED = (phase ? 0 : REG0 slice) ^ invert mask.
  - A write to REG2 while the counter is above the new value: the counter continues incrementing to 2^32-1, then wraps to 0 and toggles phase. No lockup.
  - Clearing blink_en mid-period: counter and phase reset to 0 on the next edge.
- Reset mid-transaction: any pending AW, W, B or R is discarded. The master must reissue after reset.

Decomposition:
- Shared package led_axil_pkg holds:
  - register index constants REG_LED=0, REG_CTRL=1, REG_PERIOD=2, REG_SCRATCH=3;
  - CTRL bit positions;
  - RESP_OKAY=2'b00.
- One sub-module, led_blink_gen: inputs REG0, REG1 and REG2 fields; output LED. Contains the counter and phase flop.

Test Plan:
- Sequential write then read: write 0x1, 0x2, 0x3, 0x4 to 0x0, 0x4, 0x8, 0xC, then read the same addresses -> RDATA 0x1..0x4, every response OKAY.
- AW early, W late: AWVALID at cycle 0, WVALID at cycle 5 -> AWREADY drops after the AW handshake, commit and BVALID in cycle 6. Repeat with W first -> same result.
- Byte strobes: REG3=0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> REG3 reads 0xFF34FF78.
- Backpressure: hold BREADY=0 for 10 cycles -> BVALID stays 1, AWREADY and WREADY stay 0. Hold RREADY=0 -> RDATA stable, ARREADY=0.
- Blink: REG0=0xA5, REG2=3, REG1=0x1 -> LED alternates 0xA5 and 0x00 every 4 cycles. REG1=0x3 -> LED alternates 0x5A and 0xFF.
- Reset mid-read: assert ARESETN=0 while RVALID=1 -> RVALID, LED and all registers read 0 after release.
